// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults and elaboration-time helpers for the streaming
// convolution engine.
//   - default parameter values (pixel/weight width, accumulator width,
//     image side, kernel side, stride, channel count)
//   - idx_t: width of the output-map row/column indices
//   - clog2 / out_dim / on_grid helper functions
package conv_pkg;

  localparam int WORD_LENGTH_DEF = 8;
  localparam int ACC_WIDTH_DEF   = 16;
  localparam int IMAGE_SIZE_DEF  = 28;
  localparam int KERNEL_SIZE_DEF = 5;
  localparam int STRIDE_DEF      = 1;
  localparam int OUT_CH_DEF      = 2;
  localparam int IDX_WIDTH       = 8;

  typedef logic [IDX_WIDTH-1:0] idx_t;

  // Number of bits needed to address 'value' distinct items.
  function automatic int clog2(input int value);
    int bits;
    bits = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        bits = i + 32'sd1;
      end
    end
    return bits;
  endfunction

  // Side length of the output map.
  function automatic int out_dim(input int image, input int kernel, input int stride);
    return (image - kernel) / stride + 32'sd1;
  endfunction

  // True when a window offset lands on the stride grid.
  function automatic logic on_grid(input int offset, input int stride);
    return (offset % stride) == 32'sd0;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 previous image rows plus a KxK sliding window.
// Ports:
//   clk      in  clock, rising edge
//   accept   in  a pixel is consumed this cycle
//   col      in  column of the pixel being consumed
//   data_in  in  pixel being consumed
//   window   out flat KxK window, tap i=r*K+c at [i*WORD +: WORD];
//                row 0 is the oldest image row, column K-1 is the current
//                column (the right-most column is combinational from data_in
//                and the row memories, so the window is complete in the same
//                cycle the last pixel arrives).
// Contents are not reset: the owner only uses the window once K-1 full rows
// and K-1 columns of the current frame have passed through.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int COL_WIDTH   = 5
) (
  input  logic                                       clk,
  input  logic                                       accept,
  input  logic [COL_WIDTH-1:0]                       col,
  input  logic [WORD_LENGTH-1:0]                     data_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*WORD_LENGTH-1:0] window
);

  // rows_r[j][x] holds the pixel at column x from j+1 rows ago.
  logic [WORD_LENGTH-1:0] rows_r [KERNEL_SIZE-1][IMAGE_SIZE];
  // cols_r[r][c] holds earlier columns of window row r; c=K-2 is the newest.
  logic [WORD_LENGTH-1:0] cols_r [KERNEL_SIZE][KERNEL_SIZE-1];
  // Current column of the window, top (oldest row) to bottom (data_in).
  logic [WORD_LENGTH-1:0] column_s [KERNEL_SIZE];

  // Assemble the newest window column from the row memories and the live pixel.
  always_comb begin
    column_s[KERNEL_SIZE-1] = data_in;
    for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
      column_s[KERNEL_SIZE-2-j] = rows_r[j][col];
    end
  end

  // Row memories behave as column-addressed delay lines; window columns shift left.
  always_ff @(posedge clk) begin
    if (accept) begin
      rows_r[0][col] <= data_in;
      for (int j = 1; j < KERNEL_SIZE - 1; j++) begin
        rows_r[j][col] <= rows_r[j-1][col];
      end
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 2; c++) begin
          cols_r[r][c] <= cols_r[r][c+1];
        end
        cols_r[r][KERNEL_SIZE-2] <= column_s[r];
      end
    end
  end

  // Flatten the stored columns and the live column into the tap vector.
  always_comb begin
    window = {(KERNEL_SIZE*KERNEL_SIZE*WORD_LENGTH){1'b0}};
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
        window[(r*KERNEL_SIZE+c)*WORD_LENGTH +: WORD_LENGTH] = cols_r[r][c];
      end
      window[(r*KERNEL_SIZE+KERNEL_SIZE-1)*WORD_LENGTH +: WORD_LENGTH] = column_s[r];
    end
  end

endmodule

// File: rtl/conv_stream_mc.sv
// conv_stream_mc: streaming multi-channel 2-D convolution engine.
// One signed pixel per handshake in raster order; one OUT_CH-wide result per
// window that lands on the stride grid.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   weight_load        pulse; latches weight_value/bias_value, honoured only at
//                      a frame boundary with no result pending
//   weight_value       ch c, tap i=r*K+col at [(c*K*K+i)*WORD +: WORD]
//   bias_value         ch c at [c*ACC +: ACC]
//   relu_en            clamp negative results to 0
//   in_valid/in_ready  input handshake, data_in is the pixel
//   out_valid/out_ready output handshake; data_out ch c at [c*ACC +: ACC]
//   out_row/out_col    output-map coordinates of data_out
//   frame_done         high together with the last result of a frame
module conv_stream_mc
  import conv_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int IMAGE_SIZE  = IMAGE_SIZE_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int STRIDE      = STRIDE_DEF,
  parameter int OUT_CH      = OUT_CH_DEF
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            weight_load,
  input  logic [OUT_CH*KERNEL_SIZE*KERNEL_SIZE*WORD_LENGTH-1:0] weight_value,
  input  logic [OUT_CH*ACC_WIDTH-1:0]                     bias_value,
  input  logic                                            relu_en,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [WORD_LENGTH-1:0]                          data_in,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [OUT_CH*ACC_WIDTH-1:0]                     data_out,
  output logic [IDX_WIDTH-1:0]                            out_row,
  output logic [IDX_WIDTH-1:0]                            out_col,
  output logic                                            frame_done
);

  localparam int KK       = KERNEL_SIZE * KERNEL_SIZE;
  localparam int CW_RAW   = clog2(IMAGE_SIZE);
  localparam int CW       = (CW_RAW < 32'sd1) ? 32'sd1 : CW_RAW;
  localparam int ODIM     = out_dim(IMAGE_SIZE, KERNEL_SIZE, STRIDE);
  localparam int PW       = 2 * WORD_LENGTH;
  localparam int WW       = OUT_CH * KK * WORD_LENGTH;
  localparam int DW       = OUT_CH * ACC_WIDTH;
  localparam logic [CW-1:0] LAST_POS = CW'(IMAGE_SIZE - 32'sd1);
  localparam logic [CW-1:0] ONE_POS  = CW'(32'sd1);
  localparam idx_t          LAST_IDX = idx_t'(ODIM - 32'sd1);

  // Geometry that cannot tile the image is rejected at elaboration.
  generate
    if ((IMAGE_SIZE - KERNEL_SIZE) % STRIDE != 32'sd0) begin : g_bad_stride
      $error("conv_stream_mc: (IMAGE_SIZE-KERNEL_SIZE) must be a multiple of STRIDE");
    end
    if (KERNEL_SIZE < 32'sd2) begin : g_bad_kernel
      $error("conv_stream_mc: KERNEL_SIZE must be at least 2");
    end
  endgenerate

  logic [CW-1:0]           row_r;
  logic [CW-1:0]           col_r;
  logic [WW-1:0]           weights_r;
  logic [DW-1:0]           bias_r;
  logic                    out_valid_r;
  logic [DW-1:0]           data_out_r;
  idx_t                    out_row_r;
  idx_t                    out_col_r;
  logic                    frame_done_r;

  logic                    accept_s;
  logic                    wload_s;
  logic                    hit_s;
  logic                    last_s;
  int                      row_off_s;
  int                      col_off_s;
  idx_t                    orow_s;
  idx_t                    ocol_s;
  logic [KK*WORD_LENGTH-1:0] window_s;
  logic [DW-1:0]           result_s;

  // A single result register: accept only when it is empty or draining.
  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;

  assign out_valid  = out_valid_r;
  assign data_out   = data_out_r;
  assign out_row    = out_row_r;
  assign out_col    = out_col_r;
  assign frame_done = frame_done_r;

  // Coefficients may only change before the first pixel of a frame with
  // nothing pending, so every result of a frame uses one coefficient set.
  assign wload_s = weight_load && (row_r == {CW{1'b0}}) && (col_r == {CW{1'b0}}) && !out_valid_r;

  conv_line_buffer #(
    .WORD_LENGTH (WORD_LENGTH),
    .IMAGE_SIZE  (IMAGE_SIZE),
    .KERNEL_SIZE (KERNEL_SIZE),
    .COL_WIDTH   (CW)
  ) u_line_buffer (
    .clk     (clk),
    .accept  (accept_s),
    .col     (col_r),
    .data_in (data_in),
    .window  (window_s)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= {CW{1'b0}};
      col_r <= {CW{1'b0}};
    end else if (accept_s) begin
      if (col_r == LAST_POS) begin
        col_r <= {CW{1'b0}};
        if (row_r == LAST_POS) begin
          row_r <= {CW{1'b0}};
        end else begin
          row_r <= row_r + ONE_POS;
        end
      end else begin
        col_r <= col_r + ONE_POS;
      end
    end
  end

  // Coefficient and bias registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights_r <= {WW{1'b0}};
      bias_r    <= {DW{1'b0}};
    end else if (wload_s) begin
      weights_r <= weight_value;
      bias_r    <= bias_value;
    end
  end

  // Window-hit detection and output-map coordinates of the incoming pixel.
  always_comb begin
    row_off_s = int'(row_r) - (KERNEL_SIZE - 32'sd1);
    col_off_s = int'(col_r) - (KERNEL_SIZE - 32'sd1);
    hit_s     = 1'b0;
    orow_s    = {IDX_WIDTH{1'b0}};
    ocol_s    = {IDX_WIDTH{1'b0}};
    if (accept_s && (row_off_s >= 32'sd0) && (col_off_s >= 32'sd0) &&
        on_grid(row_off_s, STRIDE) && on_grid(col_off_s, STRIDE)) begin
      hit_s  = 1'b1;
      orow_s = idx_t'(row_off_s / STRIDE);
      ocol_s = idx_t'(col_off_s / STRIDE);
    end else begin
      hit_s  = 1'b0;
    end
    last_s = (orow_s == LAST_IDX) && (ocol_s == LAST_IDX);
  end

  // One multiply-accumulate tree per output channel.
  generate
    for (genvar ch = 0; ch < OUT_CH; ch++) begin : g_ch
      logic signed [ACC_WIDTH-1:0] acc_s;
      logic signed [PW-1:0]        prod_s;
      logic [ACC_WIDTH-1:0]        chan_s;

      // Products are sign-extended into the accumulator; the sum wraps.
      always_comb begin
        acc_s  = $signed(bias_r[ch*ACC_WIDTH +: ACC_WIDTH]);
        prod_s = {PW{1'b0}};
        for (int i = 0; i < KK; i++) begin
          prod_s = $signed(window_s[i*WORD_LENGTH +: WORD_LENGTH]) *
                   $signed(weights_r[(ch*KK+i)*WORD_LENGTH +: WORD_LENGTH]);
          acc_s  = acc_s + ACC_WIDTH'(prod_s);
        end
        if (relu_en && acc_s[ACC_WIDTH-1]) begin
          chan_s = {ACC_WIDTH{1'b0}};
        end else begin
          chan_s = acc_s;
        end
      end

      assign result_s[ch*ACC_WIDTH +: ACC_WIDTH] = chan_s;
    end
  endgenerate

  // Result register: a new hit reloads it, a drain without a hit empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      data_out_r   <= {DW{1'b0}};
      out_row_r    <= {IDX_WIDTH{1'b0}};
      out_col_r    <= {IDX_WIDTH{1'b0}};
      frame_done_r <= 1'b0;
    end else if (hit_s) begin
      out_valid_r  <= 1'b1;
      data_out_r   <= result_s;
      out_row_r    <= orow_s;
      out_col_r    <= ocol_s;
      frame_done_r <= last_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_stream_mc.sv
// Directed bench for conv_stream_mc: a 28x28 stride-1 instance and a 27x27
// stride-2 instance share coefficient and pixel inputs; each test drives one
// of them and compares every result against a direct 2-D convolution model
// plus hand-computed constants.
module tb_conv_stream_mc;
  localparam int W  = 8;
  localparam int A  = 16;
  localparam int K  = 5;
  localparam int CH = 2;
  localparam int KK = K * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 weight_load;
  logic [CH*KK*W-1:0]   weight_value;
  logic [CH*A-1:0]      bias_value;
  logic                 relu_en;
  logic [W-1:0]         data_in;

  logic in_valid1, in_ready1, out_valid1, out_ready1, frame_done1;
  logic [CH*A-1:0] data_out1;
  logic [7:0] out_row1, out_col1;
  logic in_valid2, in_ready2, out_valid2, out_ready2, frame_done2;
  logic [CH*A-1:0] data_out2;
  logic [7:0] out_row2, out_col2;

  conv_stream_mc #(.WORD_LENGTH(8), .ACC_WIDTH(16), .IMAGE_SIZE(28),
                   .KERNEL_SIZE(5), .STRIDE(1), .OUT_CH(2)) dut1 (
    .clk(clk), .rst(rst), .weight_load(weight_load), .weight_value(weight_value),
    .bias_value(bias_value), .relu_en(relu_en), .in_valid(in_valid1),
    .in_ready(in_ready1), .data_in(data_in), .out_valid(out_valid1),
    .out_ready(out_ready1), .data_out(data_out1), .out_row(out_row1),
    .out_col(out_col1), .frame_done(frame_done1));

  conv_stream_mc #(.WORD_LENGTH(8), .ACC_WIDTH(16), .IMAGE_SIZE(27),
                   .KERNEL_SIZE(5), .STRIDE(2), .OUT_CH(2)) dut2 (
    .clk(clk), .rst(rst), .weight_load(weight_load), .weight_value(weight_value),
    .bias_value(bias_value), .relu_en(relu_en), .in_valid(in_valid2),
    .in_ready(in_ready2), .data_in(data_in), .out_valid(out_valid2),
    .out_ready(out_ready2), .data_out(data_out2), .out_row(out_row2),
    .out_col(out_col2), .frame_done(frame_done2));

  logic signed [7:0]  wm [CH][KK];
  logic signed [15:0] bm [CH];
  logic               relu_m;
  int pmode, img, str, odim, sel;
  int n_checks = 0;
  int n_fail   = 0;
  int pi, ei, stall_arm, stall_cnt, wl_a, wl_b;
  logic [CH*A-1:0] last_data;
  logic [CH*A+15:0] snap;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    case (pmode)
      0:       pix = 8'((r * img + c) % 128);
      1:       pix = 8'd1;
      default: pix = 8'd127;
    endcase
  endfunction

  // Direct convolution of the stimulus image with the model coefficients.
  function automatic logic [15:0] gold(input int ch, input int orow, input int ocol);
    int s;
    logic [7:0] p;
    s = int'(bm[ch]);
    for (int i = 0; i < KK; i++) begin
      p = pix(orow * str + i / K, ocol * str + i % K);
      s += int'($signed(p)) * int'(wm[ch][i]);
    end
    gold = 16'(s);
    if (relu_m && gold[15]) gold = 16'd0;
  endfunction

  task automatic set_kernel(input int kmode, input logic signed [15:0] b);
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < KK; i++) begin
        case (kmode)
          0:       wm[ch][i] = (i == 12) ? 8'sd1 : 8'sd0;
          1:       wm[ch][i] = (ch == 0) ? 8'sd1 : -8'sd1;
          2:       wm[ch][i] = 8'sd127;
          default: wm[ch][i] = 8'(((i * 7 + ch * 3) % 11) - 5);
        endcase
      end
      bm[ch] = b;
    end
  endtask

  task automatic load_weights();
    @(negedge clk);
    for (int ch = 0; ch < CH; ch++) begin
      for (int i = 0; i < KK; i++) weight_value[(ch*KK+i)*W +: W] = wm[ch][i];
      bias_value[ch*A +: A] = bm[ch];
    end
    weight_load = 1'b1;
    @(negedge clk);
    weight_load = 1'b0;
  endtask

  task automatic check_reset_state();
    check_eq("rst_out_valid", out_valid1, 1'b0);
    check_eq("rst_data_out", data_out1, 32'd0);
    check_eq("rst_out_row", out_row1, 8'd0);
    check_eq("rst_out_col", out_col1, 8'd0);
    check_eq("rst_frame_done", frame_done1, 1'b0);
    check_eq("rst_in_ready", in_ready1, 1'b1);
  endtask

  // One clock of stimulus and checking, all done away from the rising edge.
  task automatic step(input bit feed);
    logic ov, ir, rdy, fd, fdx;
    logic [CH*A-1:0] dout;
    logic [7:0] orr, occ;
    int er, ec, fsz, osz;
    @(negedge clk);
    fsz = img * img;
    osz = odim * odim;
    ov = sel ? out_valid2 : out_valid1;
    if (stall_arm != 0 && ov) begin
      stall_arm = 0;
      stall_cnt = 10;
      snap = {data_out1, out_row1, out_col1};
    end
    out_ready1  = (stall_cnt == 0);
    out_ready2  = 1'b1;
    weight_load = feed && (pi == wl_a || pi == wl_b);
    if (weight_load) weight_value = {CH*KK{8'h03}};
    data_in   = pix((pi % fsz) / img, pi % img);
    in_valid1 = feed && (sel == 0);
    in_valid2 = feed && (sel != 0);
    #1;
    ir   = sel ? in_ready2   : in_ready1;
    rdy  = sel ? out_ready2  : out_ready1;
    dout = sel ? data_out2   : data_out1;
    orr  = sel ? out_row2    : out_row1;
    occ  = sel ? out_col2    : out_col1;
    fd   = sel ? frame_done2 : frame_done1;
    if (stall_cnt > 0) begin
      check_eq("stall_hold", {dout, orr, occ}, snap);
      check_eq("stall_in_ready", ir, 1'b0);
      stall_cnt--;
    end
    if (ov && rdy) begin
      er  = (ei % osz) / odim;
      ec  = ei % odim;
      fdx = (er == odim - 1) && (ec == odim - 1);
      check_eq("ch0", dout[15:0], gold(0, er, ec));
      check_eq("ch1", dout[31:16], gold(1, er, ec));
      check_eq("row_col_done", {orr, occ, fd}, {8'(er), 8'(ec), fdx});
      last_data = dout;
      ei++;
    end
    if (feed && ir) pi++;
  endtask

  task automatic run(input int npix, input int drain, input int nres);
    int guard;
    pi = 0;
    ei = 0;
    guard = 0;
    while (pi < npix && guard < npix + 100) begin
      step(1'b1);
      guard++;
    end
    for (int i = 0; i < drain; i++) step(1'b0);
    check_eq("pixels_fed", pi, npix);
    check_eq("result_count", ei, nres);
  endtask

  initial begin
    rst = 1'b1; weight_load = 1'b0; weight_value = '0; bias_value = '0;
    relu_en = 1'b0; data_in = 8'd0;
    in_valid1 = 1'b0; in_valid2 = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    sel = 0; pmode = 0; img = 28; str = 1; odim = 24; relu_m = 1'b0;
    stall_arm = 0; stall_cnt = 0; wl_a = -1; wl_b = -1; pi = 0; ei = 0;
    last_data = '0; snap = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_state();
    @(negedge clk) rst = 1'b0;

    // Identity kernel: out(r,c) = in(r+2,c+2); last is in(25,25)=85.
    set_kernel(0, 16'sd0); load_weights();
    run(784, 3, 576);
    check_eq("t1_last", last_data, 32'h0055_0055);

    // All-ones image, +1/-1 kernels, bias 14: 39 and -11.
    pmode = 1; set_kernel(1, 16'sd14); load_weights();
    run(784, 3, 576);
    check_eq("t2_norelu", last_data, 32'hFFF5_0027);
    relu_m = 1'b1; relu_en = 1'b1;
    run(784, 3, 576);
    check_eq("t2_relu", last_data, 32'h0000_0027);

    // Full-scale positive values wrap modulo 2^16.
    relu_m = 1'b0; relu_en = 1'b0;
    pmode = 2; set_kernel(2, 16'sd0); load_weights();
    run(784, 3, 576);
    check_eq("t5_wrap", last_data, 32'h2719_2719);

    // Back-pressure: hold out_ready low for 10 cycles at the first result.
    pmode = 0; set_kernel(3, 16'sd100); load_weights();
    stall_arm = 1;
    run(784, 3, 576);

    // Mid-frame reset, then two back-to-back frames; both coefficient
    // loads attempted during the run must be ignored.
    set_kernel(3, -16'sd50); relu_m = 1'b1; relu_en = 1'b1; load_weights();
    run(300, 0, 159);
    @(negedge clk);
    rst = 1'b1; in_valid1 = 1'b0;
    #1 check_reset_state();
    @(negedge clk) rst = 1'b0;
    load_weights();
    wl_a = 400; wl_b = 784;
    run(1568, 3, 1152);
    wl_a = -1; wl_b = -1;

    // Stride-2 instance on a 27x27 image: 12x12 outputs; last is in(24,24)=32.
    relu_m = 1'b0; relu_en = 1'b0;
    sel = 1; img = 27; str = 2; odim = 12;
    set_kernel(0, 16'sd0); load_weights();
    run(729, 3, 144);
    check_eq("t4_last", last_data, 32'h0020_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
